// File: rtl/fp_run_ctrl.sv
// Run controller for one float-add program execution: arbitrates the data-memory
// port, launches the core, watches for done under a watchdog and fetches the result.
module fp_run_ctrl #(
    parameter int RESULT_ADDR    = 12,
    parameter int TIMEOUT_CYCLES = 2000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             host_req,
    input  logic             host_we,
    input  logic [7:0]       host_addr,
    input  logic [7:0]       host_wdata,
    output logic             host_gnt,
    output logic [7:0]       host_rdata,
    output logic             core_start,
    input  logic             core_done,
    input  logic             core_we,
    input  logic [7:0]       core_addr,
    input  logic [7:0]       core_wdata,
    output logic             dm_we,
    output logic [7:0]       dm_addr,
    output logic [7:0]       dm_wdata,
    input  logic [7:0]       dm_rdata,
    output logic             busy,
    output logic             ack,
    output logic [15:0]      result,
    output logic [CNT_W-1:0] cycle_count,
    output logic             timeout
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_FETCH_LO, S_FETCH_HI, S_DONE
    } state_t;

    localparam logic [7:0]       RES_LO = 8'(RESULT_ADDR);
    localparam logic [7:0]       RES_HI = 8'(RESULT_ADDR + 1);
    localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT_CYCLES);

    state_t           state_q, state_d;
    logic             seen_low_q, seen_low_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0]      result_q, result_d;
    logic             timeout_q, timeout_d;
    logic             core_start_q, core_start_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             done_acc;

    always_comb begin
        state_d    = state_q;
        seen_low_d = seen_low_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        done_acc   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    state_d   = S_LAUNCH;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            S_LAUNCH: begin
                seen_low_d = 1'b0;
                cnt_d      = cnt_inc;
                state_d    = S_RUN;
            end
            S_RUN: begin
                cnt_d    = cnt_inc;
                // A done level only counts once it has been seen low in this run.
                done_acc = core_done && seen_low_q;
                if (!core_done) begin
                    seen_low_d = 1'b1;
                end
                // The watchdog looks at the count including this cycle, so a
                // timed-out run reports exactly TIMEOUT_CYCLES.
                if (done_acc) begin
                    state_d = S_FETCH_LO;
                end else if (cnt_inc >= TMO) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                    result_d  = '0;
                end
            end
            S_FETCH_LO: begin
                result_d[7:0] = dm_rdata;
                state_d       = S_FETCH_HI;
            end
            S_FETCH_HI: begin
                result_d[15:8] = dm_rdata;
                state_d        = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        core_start_d = (state_d == S_LAUNCH);
        busy_d       = (state_d == S_LAUNCH) || (state_d == S_RUN) ||
                       (state_d == S_FETCH_LO) || (state_d == S_FETCH_HI);
        ack_d        = (state_d == S_DONE);
    end

    always_comb begin
        host_gnt = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = '0;
        dm_wdata = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                host_gnt = host_req;
                dm_we    = host_req & host_we;
                dm_addr  = host_req ? host_addr : 8'h00;
                dm_wdata = host_req ? host_wdata : 8'h00;
            end
            S_LAUNCH, S_RUN: begin
                dm_we    = core_we;
                dm_addr  = core_addr;
                dm_wdata = core_wdata;
            end
            S_FETCH_LO: dm_addr = RES_LO;
            S_FETCH_HI: dm_addr = RES_HI;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            seen_low_q   <= 1'b0;
            cnt_q        <= '0;
            result_q     <= '0;
            timeout_q    <= 1'b0;
            core_start_q <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            seen_low_q   <= seen_low_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            timeout_q    <= timeout_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
        end
    end

    assign host_rdata  = dm_rdata;
    assign core_start  = core_start_q;
    assign busy        = busy_q;
    assign ack         = ack_q;
    assign result      = result_q;
    assign cycle_count = cnt_q;
    assign timeout     = timeout_q;
endmodule

// File: tb/tb_fp_run_ctrl.sv
// Bench for fp_run_ctrl: two instances (long and short watchdog), each with its own
// memory model; run outcomes are predicted from the done waveform of each run.
module tb_fp_run_ctrl;
    localparam int T_A = 2000;
    localparam int T_B = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        go         [2];
    logic        host_req   [2];
    logic        host_we    [2];
    logic [7:0]  host_addr  [2];
    logic [7:0]  host_wdata [2];
    logic        host_gnt   [2];
    logic [7:0]  host_rdata [2];
    logic        core_start [2];
    logic        core_done  [2];
    logic        core_we    [2];
    logic [7:0]  core_addr  [2];
    logic [7:0]  core_wdata [2];
    logic        dm_we      [2];
    logic [7:0]  dm_addr    [2];
    logic [7:0]  dm_wdata   [2];
    logic [7:0]  dm_rdata   [2];
    logic        busy       [2];
    logic        ack        [2];
    logic [15:0] result     [2];
    logic [15:0] cycle_count[2];
    logic        timeout    [2];
    logic [7:0]  mem [2][256];

    int checks = 0;
    int errors = 0;

    fp_run_ctrl #(.RESULT_ADDR(12), .TIMEOUT_CYCLES(T_A), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .go(go[0]),
        .host_req(host_req[0]), .host_we(host_we[0]), .host_addr(host_addr[0]),
        .host_wdata(host_wdata[0]), .host_gnt(host_gnt[0]), .host_rdata(host_rdata[0]),
        .core_start(core_start[0]), .core_done(core_done[0]), .core_we(core_we[0]),
        .core_addr(core_addr[0]), .core_wdata(core_wdata[0]),
        .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]), .dm_rdata(dm_rdata[0]),
        .busy(busy[0]), .ack(ack[0]), .result(result[0]),
        .cycle_count(cycle_count[0]), .timeout(timeout[0])
    );

    fp_run_ctrl #(.RESULT_ADDR(12), .TIMEOUT_CYCLES(T_B), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .go(go[1]),
        .host_req(host_req[1]), .host_we(host_we[1]), .host_addr(host_addr[1]),
        .host_wdata(host_wdata[1]), .host_gnt(host_gnt[1]), .host_rdata(host_rdata[1]),
        .core_start(core_start[1]), .core_done(core_done[1]), .core_we(core_we[1]),
        .core_addr(core_addr[1]), .core_wdata(core_wdata[1]),
        .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]), .dm_rdata(dm_rdata[1]),
        .busy(busy[1]), .ack(ack[1]), .result(result[1]),
        .cycle_count(cycle_count[1]), .timeout(timeout[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (dm_we[i]) mem[i][dm_addr[i]] <= dm_wdata[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) dm_rdata[i] = mem[i][dm_addr[i]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet(input int u);
        go[u] = 0; host_req[u] = 0; host_we[u] = 0; host_addr[u] = 0; host_wdata[u] = 0;
        core_done[u] = 0; core_we[u] = 0; core_addr[u] = 0; core_wdata[u] = 0;
    endtask

    task automatic host_write(input int u, input logic [7:0] a, input logic [7:0] d);
        host_req[u] = 1; host_we[u] = 1; host_addr[u] = a; host_wdata[u] = d;
        #1;
        check("host_gnt_wr", 32'(host_gnt[u]), 1);
        check("dm_we_host", 32'(dm_we[u]), 1);
        tick();
        host_we[u] = 0;
        #1;
        check("host_rdata", 32'(host_rdata[u]), 32'(d));
        host_req[u] = 0;
        $display("host write u%0d addr %02h data %02h", u, a, d);
    endtask

    // Expected outcome comes from the done waveform: done is taken at the first high
    // RUN cycle preceded by a low one, unless the run has already used up the watchdog.
    task automatic do_run(input int u, input int tmo, input int stale, input int low,
                          input logic [15:0] res, input bit arb);
        int k_acc, exp_cnt, ack_rel, run_last;
        bit exp_to, arb_now;
        logic [7:0] arb_old;
        k_acc    = (low > 0) ? stale + low + 1 : (1 << 30);
        exp_to   = (1 + k_acc > tmo);
        exp_cnt  = exp_to ? tmo : 1 + k_acc;
        ack_rel  = exp_to ? tmo : k_acc + 3;
        run_last = exp_to ? tmo - 1 : k_acc;
        arb_old  = mem[u][8'h20];
        go[u] = 1;
        tick();
        go[u] = 0;
        for (int r = 0; r <= ack_rel + 2; r++) begin
            core_we[u] = 0; core_addr[u] = 0; core_wdata[u] = 0;
            host_req[u] = 0; host_we[u] = 0;
            arb_now = arb && (r == 3) && (run_last >= 3);
            if (r == 0) core_done[u] = (stale > 0);
            else if (r <= run_last) core_done[u] = (r <= stale) ? 1'b1 : (r <= stale + low) ? 1'b0 : 1'b1;
            else core_done[u] = 1'($urandom_range(0, 1));
            go[u] = (r < ack_rel) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (r == 1) begin core_we[u] = 1; core_addr[u] = 8'd12; core_wdata[u] = res[7:0]; end
            if (r == 2) begin core_we[u] = 1; core_addr[u] = 8'd13; core_wdata[u] = res[15:8]; end
            if (arb_now) begin
                core_we[u] = 1'($urandom_range(0, 1)); core_addr[u] = 8'h40;
                core_wdata[u] = 8'($urandom);
                host_req[u] = 1; host_we[u] = 1; host_addr[u] = 8'h20; host_wdata[u] = ~arb_old;
            end
            #1;
            if (arb_now) begin
                check("arb_gnt", 32'(host_gnt[u]), 0);
                check("arb_dm_we", 32'(dm_we[u]), 32'(core_we[u]));
                check("arb_dm_addr", 32'(dm_addr[u]), 32'h40);
            end
            check("core_start", 32'(core_start[u]), 32'(r == 0));
            check("busy", 32'(busy[u]), 32'(r < ack_rel));
            check("ack", 32'(ack[u]), 32'(r >= ack_rel));
            check("timeout_lvl", 32'(timeout[u]), 32'(exp_to && r >= ack_rel));
            check("cycle_cnt", 32'(cycle_count[u]), 32'((r < exp_cnt) ? r : exp_cnt));
            tick();
        end
        go[u] = 0; core_done[u] = 0; host_req[u] = 0; host_we[u] = 0; core_we[u] = 0;
        check("result", 32'(result[u]), exp_to ? 32'h0 : 32'(res));
        check("count_final", 32'(cycle_count[u]), 32'(exp_cnt));
        check("timeout_final", 32'(timeout[u]), 32'(exp_to));
        if (arb) check("mem_protect", 32'(mem[u][8'h20]), 32'(arb_old));
        $display("run u%0d stale %0d low %0d -> result %04h count %0d timeout %0d",
                 u, stale, low, result[u], cycle_count[u], timeout[u]);
    endtask

    initial begin
        quiet(0);
        quiet(1);
        reset = 1;
        tick();
        tick();
        reset = 0;
        for (int u = 0; u < 2; u++) begin
            check("rst_ack", 32'(ack[u]), 0);
            check("rst_busy", 32'(busy[u]), 0);
            check("rst_start", 32'(core_start[u]), 0);
            check("rst_timeout", 32'(timeout[u]), 0);
            check("rst_result", 32'(result[u]), 0);
            check("rst_count", 32'(cycle_count[u]), 0);
        end

        // Operands, then a nominal run with done 40 cycles after start.
        host_write(0, 8'd8,  8'h04);
        host_write(0, 8'd9,  8'h1A);
        host_write(0, 8'd10, 8'h04);
        host_write(0, 8'd11, 8'h1A);
        host_write(0, 8'h20, 8'h11);
        do_run(0, T_A, 0, 39, 16'h1E04, 1'b1);
        host_write(0, 8'h20, 8'h77);

        do_run(0, T_A, 5, 1, 16'($urandom), 1'b1);
        do_run(0, T_A, 0, 1, 16'($urandom), 1'b0);

        do_run(1, T_B, 0, 1000, 16'($urandom), 1'b0);
        do_run(1, T_B, 0, 18, 16'($urandom), 1'b1);
        do_run(1, T_B, 0, 19, 16'($urandom), 1'b0);

        for (int i = 0; i < 8; i++) begin
            do_run(i % 2, (i % 2 == 0) ? T_A : T_B, $urandom_range(0, 4),
                   $urandom_range(1, 24), 16'($urandom), 1'b1);
        end

        // Abort mid-run: everything returns to the idle picture at once.
        do_run(0, T_A, 0, 2, 16'hBEEF, 1'b0);
        go[0] = 1;
        tick();
        go[0] = 0;
        core_done[0] = 0;
        repeat (4) tick();
        reset = 1;
        tick();
        reset = 0;
        host_req[0] = 1; host_we[0] = 0; host_addr[0] = 8'd8;
        #1;
        check("abort_busy", 32'(busy[0]), 0);
        check("abort_ack", 32'(ack[0]), 0);
        check("abort_start", 32'(core_start[0]), 0);
        check("abort_timeout", 32'(timeout[0]), 0);
        check("abort_result", 32'(result[0]), 0);
        check("abort_count", 32'(cycle_count[0]), 0);
        check("abort_gnt", 32'(host_gnt[0]), 1);
        check("abort_rdata", 32'(host_rdata[0]), 32'h04);
        $display("reset mid-run u0 -> busy %0d gnt %0d", busy[0], host_gnt[0]);
        host_req[0] = 0;
        tick();
        do_run(0, T_A, 0, 1, 16'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
